// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: opcodes, flag indices, execute FSM states.
// The ITER state exists only when EXEC_MULDIV_EN is defined.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned OPC_W  = 5;

    localparam logic [OPC_W-1:0] OP_MOVE    = 5'b00000;
    localparam logic [OPC_W-1:0] OP_ADD     = 5'b00001;
    localparam logic [OPC_W-1:0] OP_SUB     = 5'b00010;
    localparam logic [OPC_W-1:0] OP_INC     = 5'b00011;
    localparam logic [OPC_W-1:0] OP_DEC     = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND     = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR      = 5'b00110;
    localparam logic [OPC_W-1:0] OP_XOR     = 5'b00111;
    localparam logic [OPC_W-1:0] OP_NOT     = 5'b01000;
    localparam logic [OPC_W-1:0] OP_ASHL    = 5'b01001;
    localparam logic [OPC_W-1:0] OP_LSHL    = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ASHR    = 5'b01011;
    localparam logic [OPC_W-1:0] OP_LSHR    = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ROTL    = 5'b01101;
    localparam logic [OPC_W-1:0] OP_ROTR    = 5'b01110;
    localparam logic [OPC_W-1:0] OP_LOAD    = 5'b01111;
    localparam logic [OPC_W-1:0] OP_STORE   = 5'b10000;
    localparam logic [OPC_W-1:0] OP_MUL     = 5'b10001;
    localparam logic [OPC_W-1:0] OP_DIV     = 5'b10010;
    localparam logic [OPC_W-1:0] OP_JUMP    = 5'b10011;
    localparam logic [OPC_W-1:0] OP_BEQZ    = 5'b10100;
    localparam logic [OPC_W-1:0] OP_BC      = 5'b10101;
    localparam logic [OPC_W-1:0] OP_BAUX    = 5'b10110;
    localparam logic [OPC_W-1:0] OP_BPAR    = 5'b10111;
    localparam logic [OPC_W-1:0] OP_COMPARE = 5'b11001;
    localparam logic [OPC_W-1:0] OP_HALT    = 5'b11111;

    typedef enum logic [1:0] {
        FLAG_Z  = 2'd0,
        FLAG_C  = 2'd1,
        FLAG_AC = 2'd2,
        FLAG_P  = 2'd3
    } flag_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef EXEC_MULDIV_EN
        ST_ITER = 2'd2,
`endif
        ST_HOLD = 2'd1
    } state_e;

    // Routing fields carried alongside the result to write-back.
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic             am;
        logic [2:0]       rd;
        logic [3:0]       mem_addr;
        logic [5:0]       instr_mem_addr;
    } route_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// 8-iteration shift/add multiplier and restoring divider (built only with EXEC_MULDIV_EN).
// done_c_o and result_c_o describe the iteration completing on the coming edge.
`ifdef EXEC_MULDIV_EN
module muldiv_iter
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              div_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_c_o,
    output logic [RES_W-1:0]  result_c_o,
    output logic              div_by_zero_o
);

    logic              busy_q, busy_d;
    logic              div_q;
    logic [DATA_W-1:0] b_q;
    logic [RES_W-1:0]  work_q, work_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   sum9;
    logic [DATA_W-1:0] q_sh;

    // Multiply: work = {partial, multiplier}; divide: work = {remainder, quotient}.
    always_comb begin
        rem_sh = {work_q[15:8], work_q[7]};
        q_sh   = {work_q[6:0], 1'b0};
        sum9   = {1'b0, work_q[15:8]} + (work_q[0] ? {1'b0, b_q} : 9'd0);
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (div_q) begin
            if (rem_sh >= {1'b0, b_q}) begin
                work_d = {8'(rem_sh - {1'b0, b_q}), q_sh | 8'h01};
            end else begin
                work_d = {rem_sh[7:0], q_sh};
            end
        end else begin
            work_d = {sum9, work_q[7:1]};
        end
        if (busy_q) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            b_q    <= '0;
            work_q <= '0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            div_q  <= div_i;
            b_q    <= b_i;
            work_q <= {8'h00, a_i};
            cnt_q  <= '0;
        end else if (busy_q) begin
            busy_q <= busy_d;
            work_q <= work_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_c_o      = busy_q && (cnt_q == 3'd7);
    assign result_c_o    = work_d;
    assign div_by_zero_o = (b_q == '0);

endmodule
`endif

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus optional iterative MUL/DIV, valid/ready on both sides.
// EXEC_MULDIV_EN enables the muldiv_iter unit and the ITER state.
module execute_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              am,
    input  logic [2:0]        rd,
    input  logic [3:0]        mem_addr,
    input  logic [5:0]        instr_mem_addr,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  ex_opcode,
    output logic              ex_am,
    output logic [2:0]        ex_rd,
    output logic [3:0]        ex_mem_addr,
    output logic [5:0]        ex_instr_mem_addr,
    output logic [RES_W-1:0]  alu_out,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              auxiliary_flag,
    output logic              parity_flag,
    output logic              halted
);

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [RES_W-1:0]  alu_out_q, alu_out_d;
    logic [3:0]        flags_q, flags_d;
    route_t            route_q, route_d;
    logic              halted_q, halted_d;
    logic              accept_c;

    logic [DATA_W-1:0] addend;
    logic [DATA_W:0]   sum9, diff9;
    logic [4:0]        half5;
    logic [DATA_W-1:0] sc_res;
    logic              sc_wr_zp, sc_wr_ca, sc_c, sc_ac;

`ifdef EXEC_MULDIV_EN
    logic              md_start_c, md_busy, md_done_c, md_dbz;
    logic [RES_W-1:0]  md_result_c;

    muldiv_iter u_muldiv (
        .clk           (clk),
        .rst           (rst),
        .start_i       (md_start_c),
        .div_i         (opcode == OP_DIV),
        .a_i           (op_a),
        .b_i           (op_b),
        .busy_o        (md_busy),
        .done_c_o      (md_done_c),
        .result_c_o    (md_result_c),
        .div_by_zero_o (md_dbz)
    );
`endif

    assign in_ready = !halted_q && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
    assign accept_c = in_valid && in_ready;

    // Single-cycle result and flag-write qualifiers for the presented instruction.
    always_comb begin
        addend   = ((opcode == OP_INC) || (opcode == OP_DEC)) ? 8'h01 : op_b;
        sum9     = {1'b0, op_a} + {1'b0, addend};
        diff9    = {1'b0, op_a} - {1'b0, addend};
        half5    = {1'b0, op_a[3:0]} + {1'b0, addend[3:0]};
        sc_res   = '0;
        sc_wr_zp = 1'b0;
        sc_wr_ca = 1'b0;
        sc_c     = 1'b0;
        sc_ac    = 1'b0;
        case (opcode)
            OP_MOVE: begin
                sc_res   = op_b;
                sc_wr_zp = 1'b1;
            end
            OP_ADD, OP_INC: begin
                sc_res   = sum9[7:0];
                sc_wr_zp = 1'b1;
                sc_wr_ca = 1'b1;
                sc_c     = sum9[8];
                sc_ac    = half5[4];
            end
            OP_SUB, OP_DEC, OP_COMPARE: begin
                if (opcode != OP_COMPARE) begin
                    sc_res = diff9[7:0];
                end else if (op_a > op_b) begin
                    sc_res = 8'h01;
                end else if (op_a == op_b) begin
                    sc_res = 8'h00;
                end else begin
                    sc_res = 8'hFF;
                end
                sc_wr_zp = 1'b1;
                sc_wr_ca = 1'b1;
                sc_c     = diff9[8];
                sc_ac    = (op_a[3:0] < addend[3:0]);
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                case (opcode)
                    OP_AND:  sc_res = op_a & op_b;
                    OP_OR:   sc_res = op_a | op_b;
                    OP_XOR:  sc_res = op_a ^ op_b;
                    default: sc_res = ~op_a;
                endcase
                sc_wr_zp = 1'b1;
                sc_wr_ca = 1'b1;
            end
            OP_ASHL, OP_LSHL, OP_ASHR, OP_LSHR, OP_ROTL, OP_ROTR: begin
                case (opcode)
                    OP_ASHL, OP_LSHL: sc_res = {op_a[6:0], 1'b0};
                    OP_ASHR:          sc_res = {op_a[7], op_a[7:1]};
                    OP_LSHR:          sc_res = {1'b0, op_a[7:1]};
                    OP_ROTL:          sc_res = {op_a[6:0], op_a[7]};
                    default:          sc_res = {op_a[0], op_a[7:1]};
                endcase
                sc_wr_zp = 1'b1;
                sc_wr_ca = 1'b1;
                sc_c     = ((opcode == OP_ASHL) || (opcode == OP_LSHL) || (opcode == OP_ROTL))
                           ? op_a[7] : op_a[0];
            end
            OP_LOAD, OP_STORE: sc_res = op_a;
            default: sc_res = '0;
        endcase
    end

    // Next-state, result and flag register updates.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_out_d   = alu_out_q;
        flags_d     = flags_q;
        route_d     = route_q;
        halted_d    = halted_q;
`ifdef EXEC_MULDIV_EN
        md_start_c  = 1'b0;
`endif
        case (state_q)
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
`ifdef EXEC_MULDIV_EN
            ST_ITER: begin
                if (md_busy && md_done_c) begin
                    state_d          = ST_HOLD;
                    out_valid_d      = 1'b1;
                    alu_out_d        = md_result_c;
                    flags_d[FLAG_Z]  = (md_result_c == '0);
                    flags_d[FLAG_P]  = even_parity(md_result_c[7:0]);
                    flags_d[FLAG_AC] = 1'b0;
                    flags_d[FLAG_C]  = (route_q.opcode == OP_DIV) ? md_dbz
                                                                  : (md_result_c[15:8] != '0);
                end
            end
`endif
            default: ;
        endcase
        if (accept_c) begin
            route_d.opcode         = opcode;
            route_d.am             = am;
            route_d.rd             = rd;
            route_d.mem_addr       = mem_addr;
            route_d.instr_mem_addr = instr_mem_addr;
            if (opcode == OP_HALT) begin
                halted_d = 1'b1;
            end
`ifdef EXEC_MULDIV_EN
            if ((opcode == OP_MUL) || (opcode == OP_DIV)) begin
                state_d     = ST_ITER;
                out_valid_d = 1'b0;
                md_start_c  = 1'b1;
            end else
`endif
            begin
                state_d     = ST_HOLD;
                out_valid_d = 1'b1;
                alu_out_d   = {8'h00, sc_res};
                if (sc_wr_zp) begin
                    flags_d[FLAG_Z] = (sc_res == '0);
                    flags_d[FLAG_P] = even_parity(sc_res);
                end
                if (sc_wr_ca) begin
                    flags_d[FLAG_C]  = sc_c;
                    flags_d[FLAG_AC] = sc_ac;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            flags_q     <= '0;
            route_q     <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
            route_q     <= route_d;
            halted_q    <= halted_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign alu_out           = alu_out_q;
    assign ex_opcode         = route_q.opcode;
    assign ex_am             = route_q.am;
    assign ex_rd             = route_q.rd;
    assign ex_mem_addr       = route_q.mem_addr;
    assign ex_instr_mem_addr = route_q.instr_mem_addr;
    assign zero_flag         = flags_q[FLAG_Z];
    assign carry_flag        = flags_q[FLAG_C];
    assign auxiliary_flag    = flags_q[FLAG_AC];
    assign parity_flag       = flags_q[FLAG_P];
    assign halted            = halted_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table of single-cycle ops plus
// hand sequences for backpressure, MUL/DIV iteration, reset mid-op and HALT.
module tb_execute_stage;
    import cpu_pkg::*;

    logic        clk, rst, in_valid, in_ready, am, out_valid, out_ready;
    logic [4:0]  opcode, ex_opcode;
    logic [2:0]  rd, ex_rd;
    logic [3:0]  mem_addr, ex_mem_addr;
    logic [5:0]  instr_mem_addr, ex_instr_mem_addr;
    logic [7:0]  op_a, op_b;
    logic        ex_am;
    logic [15:0] alu_out;
    logic        zero_flag, carry_flag, auxiliary_flag, parity_flag, halted;
    logic [3:0]  fl;

    int n_vec = 0;
    int n_err = 0;

    execute_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .am(am), .rd(rd), .mem_addr(mem_addr),
        .instr_mem_addr(instr_mem_addr), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .ex_opcode(ex_opcode),
        .ex_am(ex_am), .ex_rd(ex_rd), .ex_mem_addr(ex_mem_addr),
        .ex_instr_mem_addr(ex_instr_mem_addr), .alu_out(alu_out),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .auxiliary_flag(auxiliary_flag), .parity_flag(parity_flag), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags packed as {P, AC, C, Z}.
    assign fl = {parity_flag, auxiliary_flag, carry_flag, zero_flag};

    typedef struct {
        logic [4:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] alu;
        logic [3:0]  fl;
        logic [3:0]  mask;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] alu, input logic [3:0] f, input logic [3:0] m);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.alu = alu; v.fl = f; v.mask = m;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        opcode = op; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
    endtask

`ifdef EXEC_MULDIV_EN
    // Accept a MUL/DIV, confirm it stays busy for 7 edges, result on the 8th.
    task automatic muldiv(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_alu, input logic [3:0] exp_fl,
                          input logic [3:0] m);
        drive(op, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("md_accept", {out_valid, in_ready, ex_opcode}, {1'b0, 1'b0, op});
        for (int it = 1; it <= 8; it++) begin
            @(posedge clk); #1;
            if (it < 8) begin
                check("md_iter", {out_valid, in_ready}, 2'b00);
            end else begin
                check("md_result", {out_valid, alu_out}, {1'b1, exp_alu});
                check("md_flags", fl & m, exp_fl & m);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; am = 1'b0;
        rd = '0; mem_addr = '0; instr_mem_addr = '0; op_a = '0; op_b = '0;

        add(OP_ADD,     8'hF8, 8'h0F, 16'h0007, 4'b0110, 4'hF);
        add(OP_ADD,     8'h08, 8'h08, 16'h0010, 4'b0100, 4'hF);
        add(OP_SUB,     8'h05, 8'h05, 16'h0000, 4'b1001, 4'hF);
        add(OP_SUB,     8'h03, 8'h05, 16'h00FE, 4'b0110, 4'hF);
        add(OP_INC,     8'hFF, 8'h00, 16'h0000, 4'b1111, 4'hF);
        add(OP_DEC,     8'h10, 8'h00, 16'h000F, 4'b1100, 4'hF);
        add(OP_AND,     8'hF0, 8'h3C, 16'h0030, 4'b1000, 4'hF);
        add(OP_OR,      8'h0A, 8'h50, 16'h005A, 4'b1000, 4'hF);
        add(OP_XOR,     8'hFF, 8'h0F, 16'h00F0, 4'b1000, 4'hF);
        add(OP_NOT,     8'h01, 8'h00, 16'h00FE, 4'b0000, 4'hF);
        add(OP_ASHR,    8'h81, 8'h00, 16'h00C0, 4'b1010, 4'hF);
        add(OP_LSHR,    8'h81, 8'h00, 16'h0040, 4'b0010, 4'hF);
        add(OP_ASHL,    8'h81, 8'h00, 16'h0002, 4'b0010, 4'hF);
        add(OP_ROTL,    8'h81, 8'h00, 16'h0003, 4'b1010, 4'hF);
        add(OP_ROTR,    8'h01, 8'h00, 16'h0080, 4'b0010, 4'hF);
        add(OP_LOAD,    8'h00, 8'h00, 16'h0000, 4'b0010, 4'hF);
        add(OP_COMPARE, 8'h10, 8'h20, 16'h00FF, 4'b1010, 4'hF);
        add(OP_COMPARE, 8'h20, 8'h10, 16'h0001, 4'b0000, 4'hF);
        add(OP_COMPARE, 8'h33, 8'h33, 16'h0000, 4'b1001, 4'hF);
        add(OP_JUMP,    8'h5A, 8'hA5, 16'h0000, 4'b1001, 4'hF);
        add(OP_BC,      8'h01, 8'h02, 16'h0000, 4'b1001, 4'hF);
        add(5'b11000,   8'h7F, 8'h01, 16'h0000, 4'b1001, 4'hF);
        add(5'b11110,   8'h7F, 8'h01, 16'h0000, 4'b1001, 4'hF);
`ifndef EXEC_MULDIV_EN
        add(OP_MUL,     8'hFF, 8'hFF, 16'h0000, 4'b1001, 4'hF);
        add(OP_DIV,     8'h55, 8'h00, 16'h0000, 4'b1001, 4'hF);
`endif
        add(OP_STORE,   8'h7E, 8'h00, 16'h007E, 4'b1001, 4'hF);
        add(OP_LSHL,    8'h40, 8'h00, 16'h0080, 4'b0000, 4'hF);
        add(OP_MOVE,    8'h11, 8'h3C, 16'h003C, 4'b1000, 4'b1001);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset", {out_valid, alu_out, fl, halted, ex_opcode, ex_am, ex_rd,
                        ex_mem_addr, ex_instr_mem_addr, in_ready},
              {1'b0, 16'h0, 4'h0, 1'b0, 5'h0, 1'b0, 3'h0, 4'h0, 6'h0, 1'b1});
        @(negedge clk) rst = 1'b0;

        // Back-to-back single-cycle vectors
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            am = i[0]; rd = 3'(i); mem_addr = 4'(i); instr_mem_addr = 6'(i + 7);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check($sformatf("vec%0d", i),
                  {out_valid, ex_opcode, ex_am, ex_rd, ex_mem_addr, ex_instr_mem_addr, alu_out},
                  {1'b1, vecs[i].op, i[0], 3'(i), 4'(i), 6'(i + 7), vecs[i].alu});
            check($sformatf("vec%0d_flags", i), fl & vecs[i].mask, vecs[i].fl & vecs[i].mask);
        end

        // Backpressure: SUB result held, then BEQZ accepted on the release edge
        drive(OP_SUB, 8'h05, 8'h05);
        @(posedge clk); #1;
        check("sub_zero", {out_valid, alu_out, fl}, {1'b1, 16'h0000, 4'b1001});
        @(negedge clk);
        opcode = OP_BEQZ; op_a = 8'h00; op_b = 8'h00; in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("hold_stable", {out_valid, in_ready, ex_opcode, alu_out, fl},
                  {1'b1, 1'b0, OP_SUB, 16'h0000, 4'b1001});
        end
        @(negedge clk) out_ready = 1'b1;
        #1 check("hold_release_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("beqz", {out_valid, ex_opcode, alu_out, fl}, {1'b1, OP_BEQZ, 16'h0000, 4'b1001});

`ifdef EXEC_MULDIV_EN
        muldiv(OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 4'b0010, 4'hF);
        muldiv(OP_MUL, 8'h03, 8'h00, 16'h0000, 4'b1001, 4'hF);
        muldiv(OP_DIV, 8'hC8, 8'h07, 16'h041C, 4'b0000, 4'b1001);
        muldiv(OP_DIV, 8'h55, 8'h00, 16'h55FF, 4'b1010, 4'b1011);
        drive(OP_MUL, 8'hFF, 8'hFF);
`else
        drive(OP_ADD, 8'hFF, 8'h01);
`endif
        // Reset in the middle of an operation
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("reset_mid", {out_valid, alu_out, fl, halted, ex_opcode, in_ready},
              {1'b0, 16'h0, 4'h0, 1'b0, 5'h0, 1'b1});
        @(negedge clk) rst = 1'b0;
        drive(OP_ADD, 8'h01, 8'h01);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("add_after_rst", {out_valid, alu_out}, {1'b1, 16'h0002});
        repeat (10) @(posedge clk);
        #1 check("no_stale_result", {out_valid, alu_out}, {1'b1, 16'h0002});

        // HALT: presented normally, then acceptance blocked until reset
        drive(OP_HALT, 8'h12, 8'h34);
        @(posedge clk); #1;
        check("halt", {out_valid, alu_out, halted, ex_opcode}, {1'b1, 16'h0000, 1'b1, OP_HALT});
        opcode = OP_ADD; op_a = 8'h01; op_b = 8'h01;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("halt_blocked", {in_ready, halted, ex_opcode}, {1'b0, 1'b1, OP_HALT});
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("halt_reset", {halted, in_ready, out_valid}, {1'b0, 1'b1, 1'b0});
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_halt_add", {out_valid, ex_opcode, alu_out}, {1'b1, OP_ADD, 16'h0002});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 8-bit core: accepts decoded instructions with register/memory operands, computes the 16-bit result and the four architectural flags, and hands them to write-back together with the instruction's routing fields. Single-cycle ALU ops complete in one cycle. MUL/DIV run on an 8-iteration shift/add–subtract unit. A valid/ready handshake on both sides lets write-back apply backpressure.

## Interface
- Parameters: none. Opcode encodings come from the shared package.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: the stage accepts the instruction on this edge if `in_valid` is also high.
- `opcode` in 5, `am` in 1, `rd` in 3, `mem_addr` in 4, `instr_mem_addr` in 6: decoded fields.
- `op_a` in 8, `op_b` in 8: source operands; `op_a` is the destination/first source.
- `out_valid` out 1: result registered and presented to write-back.
- `out_ready` in 1: write-back consumes the presented result on this edge.
- `ex_opcode` out 5, `ex_am` out 1, `ex_rd` out 3, `ex_mem_addr` out 4, `ex_instr_mem_addr` out 6: registered copies of the accepted fields.
- `alu_out` out 16: the result.
- `zero_flag`, `carry_flag`, `auxiliary_flag`, `parity_flag` out 1 each: architectural flag register.
- `halted` out 1: sticky; set once a HALT has been accepted.

## Operation
- **Reset values:** all outputs are 0, the FSM is IDLE, and the iteration counter is 0.
- **FSM states:** IDLE, ITER, HOLD.
  - IDLE → ITER when MUL or DIV is accepted.
  - IDLE → HOLD when any other opcode is accepted.
  - ITER → HOLD after 8 iterations.
  - HOLD → IDLE on `out_ready`. If a new instruction is accepted on the same edge, the FSM goes directly to ITER or HOLD for it.
- **Acceptance:** `in_ready = !halted && (state==IDLE || (state==HOLD && out_ready))`.
- **Result arithmetic** (`a`=`op_a`, `b`=`op_b`; high byte is 0 unless stated):
  - MOVE → b.
  - ADD → a+b, carry = bit 8, aux = carry out of bit 3.
  - SUB → a−b, carry = borrow, aux = borrow from bit 4.
  - INC → a+1; DEC → a−1 (carry and aux as for ADD/SUB).
  - AND, OR, XOR → bitwise; NOT → ~a. These clear carry and aux.
  - COMPARE → 8'h01 if a>b, 8'h00 if a==b, 8'hFF if a<b. Flags as for SUB.
  - ASHL, LSHL → a<<1. ASHR → sign-preserving a>>1. LSHR → a>>1. ROTL, ROTR → rotate by 1. Carry = the bit shifted or rotated out; aux is cleared.
  - LOAD, STORE → a. Flags unchanged.
  - MUL → 16-bit unsigned a*b. Carry = (high byte != 0); aux cleared.
  - DIV → {remainder, quotient}, unsigned.
  - DIV with b==0 → {a, 8'hFF}, carry=1, zero=0; the iteration cycles are still spent.
  - JUMP, BEQZ, BC, BAUX, BPAR, HALT → alu_out=0, flags unchanged. Branches are resolved downstream from the held flags.
- **Zero and parity:** zero = (alu_out==0) over 16 bits. parity = 1 when alu_out[7:0] has an even number of ones. Both update only for ops that write flags.
- **Unknown opcode:** alu_out=0, flags unchanged, handled as a single-cycle op.
- **HALT:** passes through to write-back normally. `halted` is set on the accept edge, and `in_ready` then stays 0 until `rst`.

## Timing
- **Single-cycle op accepted on edge E0:** `out_valid`=1 and the result are visible after E0.
- **MUL/DIV accepted on E0:** operands load on E0 and iterations run on E1..E8. The result and `out_valid` are visible after E8. Throughput is one MUL/DIV per 9 cycles.
- **Output stability:** while `out_valid && !out_ready`, every `ex_*` output, `alu_out` and the flags hold stable.
- **Flag update:** the flag register updates on the edge that makes the result visible.
- **`rst` wins over everything**, including mid-ITER: the next cycle shows the reset values and `in_ready`=1. A partial MUL/DIV is discarded.

## Configuration
- `EXEC_MULDIV_EN` defined: MUL and DIV behave as described above.
- `EXEC_MULDIV_EN` undefined: no iteration unit and no ITER state. MUL and DIV become single-cycle ops with alu_out=0 and flags unchanged.

## Structure
- **Shared package `cpu_pkg`:**
  - The 5-bit opcode constants (MOVE=00000 … COMPARE=11001, HALT=11111).
  - A flag-index enum (Z, C, AC, P).
  - The FSM state typedef.
- **Sub-module `muldiv_iter`:**
  - Interface: start, op select, a, b, busy, done, 16-bit result, div-by-zero.
  - Shift/add multiply and restoring divide, 8 iterations each.
  - Compiled only under `EXEC_MULDIV_EN`.

## Test plan
- ADD a=F8 b=0F, `out_ready`=1 → next cycle alu_out=0007, C=1, AC=1, Z=0, P=0.
- MUL a=FF b=FF → `out_valid` rises after the 8th iteration edge, alu_out=FE01, C=1, `in_ready`=0 during ITER.
- DIV a=C8 b=07 → alu_out=041C. DIV a=55 b=00 → alu_out=55FF, C=1.
- SUB 05−05 with `out_ready` held low 3 cycles → Z=1, outputs stable, `in_ready`=0. Then BEQZ is accepted on the `out_ready` edge, and Z stays 1 through the BEQZ result.
- `rst` asserted during the 4th MUL iteration → next cycle all outputs are 0 and `in_ready`=1. A following ADD 01+01 gives 0002.
- HALT accepted → presented with alu_out=0 and `halted`=1. `in_ready` stays 0 for 10+ cycles with `in_valid` high, until `rst`.
